siphash_match_filter: RTL

SIPHASH_MATCH_FILTER -- requirements
Module: siphash_match_filter

---
 rtl/siphash_match_filter_if.sv | 31 +++
 rtl/siphash_match_filter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/siphash_match_filter_if.sv
// Interface bundling the issue, hash-result, threshold and match-output
// signals of siphash_match_filter. clk and reset stay plain module ports.
//   slave  : the filter (consumes issue/hash/target/out_ready, drives results)
//   master : the surrounding logic / bench (drives stimulus, observes results)
interface siphash_match_filter_if;
  logic        issue_valid;
  logic [63:0] issue_nonce;
  logic        hash_valid;
  logic [63:0] hash_in;
  logic [63:0] target;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_nonce;
  logic [63:0] out_hash;
  logic        overflow;
  logic        align_err;
  logic [31:0] hash_count;
  logic [31:0] match_count;

  modport slave (
    input  issue_valid, issue_nonce, hash_valid, hash_in, target, out_ready,
    output out_valid, out_nonce, out_hash, overflow, align_err,
           hash_count, match_count
  );

  modport master (
    output issue_valid, issue_nonce, hash_valid, hash_in, target, out_ready,
    input  out_valid, out_nonce, out_hash, overflow, align_err,
           hash_count, match_count
  );
endinterface

// File: rtl/siphash_match_filter.sv
// siphash_match_filter: pairs issued nonces with hash results returning
// LATENCY cycles later, keeps results below an unsigned target threshold in
// a DEPTH-entry first-word-fall-through FIFO.
// Ports:
//   clk    - single rising-edge clock
//   reset  - synchronous, active-high reset
//   bus    - siphash_match_filter_if.slave: issue_valid/issue_nonce,
//            hash_valid/hash_in, target, out_valid/out_ready/out_nonce/
//            out_hash, sticky overflow/align_err, hash_count/match_count
// Optional feature: define SIPHASH_MATCH_STATS_EN to build the saturating
// checked/match counters; otherwise hash_count/match_count are tied to 0.
module siphash_match_filter #(
  parameter int unsigned LATENCY = 10,
  parameter int unsigned DEPTH   = 4
) (
  input logic                  clk,
  input logic                  reset,
  siphash_match_filter_if.slave bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [63:0] nonce;
    logic [63:0] hash;
  } entry_t;

  // Delay line for {issue_valid, issue_nonce}
  logic [LATENCY-1:0] dly_valid_q, dly_valid_d;
  logic [63:0]        dly_nonce_q [LATENCY];
  logic [63:0]        dly_nonce_d [LATENCY];

  // FIFO state
  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          overflow_q, overflow_d;
  logic          align_err_q, align_err_d;

  logic        d_valid;
  logic [63:0] d_nonce;
  logic        checked, match, full, out_valid, pop, push;

  always_comb begin
    dly_valid_d[0] = bus.issue_valid;
    dly_nonce_d[0] = bus.issue_nonce;
    for (int unsigned i = 1; i < LATENCY; i++) begin
      dly_valid_d[i] = dly_valid_q[i-1];
      dly_nonce_d[i] = dly_nonce_q[i-1];
    end
  end

  assign d_valid = dly_valid_q[LATENCY-1];
  assign d_nonce = dly_nonce_q[LATENCY-1];

  assign checked   = d_valid & bus.hash_valid;
  assign match     = checked & (bus.hash_in < bus.target);
  assign full      = (cnt_q == CW'(DEPTH));
  // Outputs are forced idle while reset is held, before the edge clears state.
  assign out_valid = ~reset & (cnt_q != '0);
  assign pop       = out_valid & bus.out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push      = match & (~full | pop);

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    overflow_d  = overflow_q | (match & full & ~pop);
    align_err_d = align_err_q | (d_valid != bus.hash_valid);
    if (push) begin
      mem_d[wr_ptr_q] = '{nonce: d_nonce, hash: bus.hash_in};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop && !push) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dly_valid_q <= '0;
      dly_nonce_q <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      overflow_q  <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      dly_valid_q <= dly_valid_d;
      dly_nonce_q <= dly_nonce_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      overflow_q  <= overflow_d;
      align_err_q <= align_err_d;
    end
  end

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    bus.out_valid = out_valid;
    bus.out_nonce = out_valid ? mem_q[rd_ptr_q].nonce : '0;
    bus.out_hash  = out_valid ? mem_q[rd_ptr_q].hash  : '0;
    bus.overflow  = overflow_q;
    bus.align_err = align_err_q;
  end

`ifdef SIPHASH_MATCH_STATS_EN
  logic [31:0] hash_cnt_q, hash_cnt_d;
  logic [31:0] match_cnt_q, match_cnt_d;

  // Dropped matches are still counted; both counters saturate.
  always_comb begin
    hash_cnt_d  = hash_cnt_q;
    match_cnt_d = match_cnt_q;
    if (checked && hash_cnt_q != '1) hash_cnt_d = hash_cnt_q + 1'b1;
    if (match && match_cnt_q != '1)  match_cnt_d = match_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hash_cnt_q  <= '0;
      match_cnt_q <= '0;
    end else begin
      hash_cnt_q  <= hash_cnt_d;
      match_cnt_q <= match_cnt_d;
    end
  end

  assign bus.hash_count  = hash_cnt_q;
  assign bus.match_count = match_cnt_q;
`else
  assign bus.hash_count  = '0;
  assign bus.match_count = '0;
`endif

endmodule
